// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard controller for a 5-stage in-order pipeline. It sequences multi-cycle
// mult/div operations sitting in the D/X latch, detects load-use hazards
// between D/X and F/D, and flushes on taken branches/jumps.
//
// Priority of the combinational pipeline controls:
//   mult/div busy  >  taken branch/jump  >  load-use
//
// Ports
//   clock                 in   rising-edge clock
//   reset                 in   asynchronous, active-low reset
//   fd_ir[31:0]           in   instruction in F/D latch
//   dx_ir[31:0]           in   instruction in D/X latch
//   branch_or_jump_taken  in   branch/jump resolved taken in X this cycle
//   md_ready              in   mult/div result ready pulse (only seen in BUSY)
//   stall_pc_fd           out  hold PC and F/D latch
//   stall_dx              out  hold D/X latch
//   flush_fd              out  load nop into F/D next edge
//   flush_dx              out  load nop into D/X next edge
//   ctrl_mult             out  registered one-cycle mult start pulse (START)
//   ctrl_div              out  registered one-cycle div start pulse (START)
//   md_busy               out  mult/div sequence in progress
//   stall_count[15:0]     out  saturating count of stalled edges
//   md_timeout            out  sticky watchdog flag
//
// Build option
//   PIPE_HAZARD_MD_TIMEOUT_EN : when defined, a 6-bit watchdog forces BUSY to
//   DONE after 48 BUSY cycles without md_ready and sets md_timeout (sticky
//   until reset). When undefined, BUSY waits indefinitely and md_timeout is 0.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        branch_or_jump_taken,
    input  logic        md_ready,
    output logic        stall_pc_fd,
    output logic        stall_dx,
    output logic        flush_fd,
    output logic        flush_dx,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        md_busy,
    output logic [15:0] stall_count,
    output logic        md_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_LW  = 5'b01000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    state_t state_reg, state_next;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic [4:0] fd_op;
    logic       dx_is_mul, dx_is_div, dx_is_md, dx_is_lw;

    assign dx_op  = dx_ir[31:27];
    assign dx_rd  = dx_ir[26:22];
    assign dx_alu = dx_ir[6:2];
    assign fd_op  = fd_ir[31:27];

    assign dx_is_mul = (dx_op == OP_ALU) && (dx_alu == ALU_MUL);
    assign dx_is_div = (dx_op == OP_ALU) && (dx_alu == ALU_DIV);
    assign dx_is_md  = dx_is_mul || dx_is_div;
    assign dx_is_lw  = (dx_op == OP_LW);

    // Bits not involved in hazard decisions.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{dx_ir[21:7], dx_ir[1:0], fd_ir[11:0]};

    // ------------------------------------------------------------------
    // Load-use detection: which F/D register fields are real sources
    // depends on the F/D opcode. Index 0 = rs, 1 = rt, 2 = rd.
    // ------------------------------------------------------------------
    logic [4:0] fd_src [3];
    logic [2:0] src_used;
    logic [2:0] src_hit;
    logic       load_use;

    assign fd_src[0] = fd_ir[21:17];
    assign fd_src[1] = fd_ir[16:12];
    assign fd_src[2] = fd_ir[26:22];

    always_comb begin
        src_used = 3'b000;
        case (fd_op)
            5'b00000: src_used = 3'b011;   // rs, rt
            5'b00101,
            5'b01000: src_used = 3'b001;   // rs
            5'b00111,
            5'b00010,
            5'b00110: src_used = 3'b101;   // rs, rd (rd read as data/compare)
            5'b00100: src_used = 3'b100;   // rd only
            default:  src_used = 3'b000;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src_match
            assign src_hit[gi] = src_used[gi] && (fd_src[gi] == dx_rd);
        end
    endgenerate

    // r0 is hardwired zero, so a load into it never creates a dependency.
    assign load_use = dx_is_lw && (dx_rd != 5'd0) && (|src_hit);

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
    logic wd_expire;

`ifdef PIPE_HAZARD_MD_TIMEOUT_EN
    logic [5:0] wd_count_reg;
    logic       md_timeout_reg;

    // Counter is 0 in the first BUSY cycle, so count 47 is the 48th.
    assign wd_expire = (state_reg == BUSY) && !md_ready && (wd_count_reg == 6'd47);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_count_reg   <= 6'd0;
            md_timeout_reg <= 1'b0;
        end else begin
            if (state_reg == START) begin
                wd_count_reg <= 6'd0;
            end else if (state_reg == BUSY) begin
                wd_count_reg <= wd_count_reg + 6'd1;
            end
            if (wd_expire) begin
                md_timeout_reg <= 1'b1;
            end
        end
    end

    assign md_timeout = md_timeout_reg;
`else
    assign wd_expire  = 1'b0;
    assign md_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Mult/div sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (dx_is_md) state_next = START;
            START:   state_next = BUSY;
            BUSY:    if (md_ready || wd_expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Start pulses are registered so they are high exactly while in START.
    logic ctrl_mult_reg, ctrl_div_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_mult_reg <= 1'b0;
            ctrl_div_reg  <= 1'b0;
        end else begin
            ctrl_mult_reg <= (state_next == START) && dx_is_mul;
            ctrl_div_reg  <= (state_next == START) && dx_is_div;
        end
    end

    assign ctrl_mult = ctrl_mult_reg;
    assign ctrl_div  = ctrl_div_reg;

    // ------------------------------------------------------------------
    // Combinational pipeline controls. While reset is asserted every
    // control is forced low so the pipeline sees a quiet controller.
    // ------------------------------------------------------------------
    always_comb begin
        md_busy     = 1'b0;
        stall_pc_fd = 1'b0;
        stall_dx    = 1'b0;
        flush_fd    = 1'b0;
        flush_dx    = 1'b0;
        if (reset) begin
            md_busy = (state_reg == START) || (state_reg == BUSY) ||
                      ((state_reg == IDLE) && dx_is_md);
            if (md_busy) begin
                // A branch cannot be in X here: X holds the mult/div.
                stall_pc_fd = 1'b1;
                stall_dx    = 1'b1;
            end else if (branch_or_jump_taken) begin
                flush_fd = 1'b1;
                flush_dx = 1'b1;
            end else if (load_use) begin
                // Hold F/D and inject a bubble into D/X for one cycle.
                stall_pc_fd = 1'b1;
                flush_dx    = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    logic [15:0] stall_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= 16'd0;
        end else if (stall_pc_fd && (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle hazard
// vectors fed through an expected-result queue, followed by hand-written
// sequences for mult/div, back-to-back div/mul, reset mid-sequence and the
// watchdog (or its absence, depending on PIPE_HAZARD_MD_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] fd_ir;
    logic [31:0] dx_ir;
    logic        branch_or_jump_taken;
    logic        md_ready;
    logic        stall_pc_fd;
    logic        stall_dx;
    logic        flush_fd;
    logic        flush_dx;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        md_busy;
    logic [15:0] stall_count;
    logic        md_timeout;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut (
        .clock                (clk),
        .reset                (reset),
        .fd_ir                (fd_ir),
        .dx_ir                (dx_ir),
        .branch_or_jump_taken (branch_or_jump_taken),
        .md_ready             (md_ready),
        .stall_pc_fd          (stall_pc_fd),
        .stall_dx             (stall_dx),
        .flush_fd             (flush_fd),
        .flush_dx             (flush_dx),
        .ctrl_mult            (ctrl_mult),
        .ctrl_div             (ctrl_div),
        .md_busy              (md_busy),
        .stall_count          (stall_count),
        .md_timeout           (md_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL time_limit: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "time limit");
    end

    // Instruction encoder: op | rd | rs | rt | shamt | alu | 00
    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    logic [31:0] ins_nop, ins_mul, ins_div;

    typedef struct {
        string       name;
        logic [31:0] fd;
        logic [31:0] dx;
        logic        br;
        logic [4:0]  exp;   // {stall_pc_fd, stall_dx, flush_fd, flush_dx, md_busy}
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] exp;
    } exp_t;

    vec_t vecs [13];
    exp_t sb_q [$];
    int   exp_cnt;

    function automatic logic [4:0] outs();
        return {stall_pc_fd, stall_dx, flush_fd, flush_dx, md_busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        fd_ir = ins_nop;
        dx_ir = ins_nop;
        branch_or_jump_taken = 1'b0;
        md_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        int n;
        int bad;

        ins_nop = 32'd0;
        ins_mul = enc(5'b00000, 5'd1, 5'd2, 5'd3, 5'b00110);
        ins_div = enc(5'b00000, 5'd4, 5'd5, 5'd6, 5'b00111);

        vecs[0]  = '{"lu_rs",          enc(5'd0, 5'd4, 5'd3, 5'd5, 5'd0), enc(5'd8, 5'd3, 5'd1, 5'd0, 5'd0), 1'b0, 5'b10010};
        vecs[1]  = '{"lu_r0",          enc(5'd0, 5'd4, 5'd0, 5'd5, 5'd0), enc(5'd8, 5'd0, 5'd1, 5'd0, 5'd0), 1'b0, 5'b00000};
        vecs[2]  = '{"lu_rt",          enc(5'd0, 5'd4, 5'd3, 5'd5, 5'd0), enc(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 1'b0, 5'b10010};
        vecs[3]  = '{"alu_rd_not_src", enc(5'd0, 5'd4, 5'd3, 5'd5, 5'd0), enc(5'd8, 5'd4, 5'd1, 5'd0, 5'd0), 1'b0, 5'b00000};
        vecs[4]  = '{"op7_rd_src",     enc(5'd7, 5'd7, 5'd2, 5'd0, 5'd0), enc(5'd8, 5'd7, 5'd1, 5'd0, 5'd0), 1'b0, 5'b10010};
        vecs[5]  = '{"op4_rs_not_src", enc(5'd4, 5'd9, 5'd7, 5'd0, 5'd0), enc(5'd8, 5'd7, 5'd1, 5'd0, 5'd0), 1'b0, 5'b00000};
        vecs[6]  = '{"op4_rd_src",     enc(5'd4, 5'd7, 5'd9, 5'd0, 5'd0), enc(5'd8, 5'd7, 5'd1, 5'd0, 5'd0), 1'b0, 5'b10010};
        vecs[7]  = '{"op5_rt_not_src", enc(5'd5, 5'd1, 5'd2, 5'd6, 5'd0), enc(5'd8, 5'd6, 5'd1, 5'd0, 5'd0), 1'b0, 5'b00000};
        vecs[8]  = '{"op5_rs_src",     enc(5'd5, 5'd1, 5'd6, 5'd2, 5'd0), enc(5'd8, 5'd6, 5'd1, 5'd0, 5'd0), 1'b0, 5'b10010};
        vecs[9]  = '{"branch_bne",     enc(5'd0, 5'd4, 5'd3, 5'd5, 5'd0), enc(5'd2, 5'd1, 5'd2, 5'd0, 5'd0), 1'b1, 5'b00110};
        vecs[10] = '{"branch_over_lu", enc(5'd0, 5'd4, 5'd3, 5'd5, 5'd0), enc(5'd8, 5'd3, 5'd1, 5'd0, 5'd0), 1'b1, 5'b00110};
        vecs[11] = '{"no_hazard",      enc(5'd0, 5'd4, 5'd3, 5'd5, 5'd0), enc(5'd0, 5'd1, 5'd2, 5'd3, 5'd0), 1'b0, 5'b00000};
        vecs[12] = '{"op1_no_src",     enc(5'd1, 5'd3, 5'd3, 5'd3, 5'd0), enc(5'd8, 5'd3, 5'd1, 5'd0, 5'd0), 1'b0, 5'b00000};

        // ---------------- reset state ----------------
        reset = 1'b0;
        fd_ir = ins_nop;
        dx_ir = ins_mul;          // outputs must still be quiet under reset
        branch_or_jump_taken = 1'b0;
        md_ready = 1'b0;
        #3;
        chk("reset_ctrl", {28'd0, outs()}, 32'd0);
        chk("reset_pulses", {29'd0, ctrl_mult, ctrl_div, md_timeout}, 32'd0);
        chk("reset_stall_count", {16'd0, stall_count}, 32'd0);
        dx_ir = ins_nop;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;

        // ---------------- table vectors via scoreboard ----------------
        for (int i = 0; i < 13; i++) begin
            step();
            fd_ir = vecs[i].fd;
            dx_ir = vecs[i].dx;
            branch_or_jump_taken = vecs[i].br;
            sb_q.push_back('{vecs[i].name, vecs[i].exp});
            @(negedge clk);
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk(e.name, {27'd0, outs()}, {27'd0, e.exp});
                chk({e.name, "_cnt"}, {16'd0, stall_count}, exp_cnt);
                if (e.exp[4]) exp_cnt++;
            end
        end
        step();
        fd_ir = ins_nop;
        dx_ir = ins_nop;
        branch_or_jump_taken = 1'b0;

        // ---------------- mul, md_ready 5 cycles after START ----------------
        do_reset();
        step();
        dx_ir = enc(5'd0, 5'd1, 5'd2, 5'd3, 5'b00110);
        fd_ir = enc(5'd0, 5'd4, 5'd3, 5'd5, 5'd0);
        @(negedge clk);
        chk("mul_idle_ctrl", {27'd0, outs()}, {27'd0, 5'b11001});
        chk("mul_idle_pulse", {31'd0, ctrl_mult}, 32'd0);
        step();
        @(negedge clk);
        chk("mul_start_pulses", {30'd0, ctrl_mult, ctrl_div}, 32'd2);
        chk("mul_start_ctrl", {27'd0, outs()}, {27'd0, 5'b11001});
        for (int b = 1; b <= 5; b++) begin
            step();
            md_ready = (b == 5);
            branch_or_jump_taken = (b == 2);
            @(negedge clk);
            chk($sformatf("mul_busy%0d_ctrl", b), {27'd0, outs()}, {27'd0, 5'b11001});
            chk($sformatf("mul_busy%0d_pulse", b), {31'd0, ctrl_mult}, 32'd0);
        end
        step();
        md_ready = 1'b0;
        branch_or_jump_taken = 1'b0;
        @(negedge clk);
        chk("mul_done_ctrl", {27'd0, outs()}, 32'd0);
        chk("mul_done_pulses", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
        chk("mul_stall_count", {16'd0, stall_count}, 32'd7);
        step();
        dx_ir = ins_nop;
        @(negedge clk);
        chk("mul_after_idle", {27'd0, outs()}, 32'd0);

        // ---------------- div directly followed by mul ----------------
        step();
        dx_ir = ins_div;
        @(negedge clk);
        chk("div_idle_busy", {31'd0, md_busy}, 32'd1);
        step();
        md_ready = 1'b1;          // must be ignored in START
        @(negedge clk);
        chk("div_start_pulses", {30'd0, ctrl_mult, ctrl_div}, 32'd1);
        step();
        @(negedge clk);
        chk("div_busy_ready_ignored", {31'd0, md_busy}, 32'd1);
        chk("div_busy_pulses", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
        step();
        md_ready = 1'b0;
        @(negedge clk);
        chk("div_done_ctrl", {27'd0, outs()}, 32'd0);
        step();
        dx_ir = ins_mul;
        @(negedge clk);
        chk("b2b_mul_idle", {29'd0, md_busy, ctrl_mult, ctrl_div}, 32'd4);
        step();
        @(negedge clk);
        chk("b2b_mul_start", {30'd0, ctrl_mult, ctrl_div}, 32'd2);
        step();
        md_ready = 1'b1;
        step();
        md_ready = 1'b0;
        @(negedge clk);
        chk("b2b_mul_done", {31'd0, md_busy}, 32'd0);
        step();
        dx_ir = ins_nop;

        // ---------------- reset held low mid-BUSY ----------------
        step();
        dx_ir = ins_mul;
        step();
        step();
        step();
        #2;
        chk("pre_reset_busy", {31'd0, md_busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_ctrl", {27'd0, outs()}, 32'd0);
        chk("arst_pulses", {29'd0, ctrl_mult, ctrl_div, md_timeout}, 32'd0);
        chk("arst_stall_count", {16'd0, stall_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_hold_ctrl", {27'd0, outs()}, 32'd0);
        dx_ir = ins_nop;
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ctrl_mult || ctrl_div || md_busy) bad++;
        end
        chk("no_restart_after_reset", bad, 0);
        step();
        dx_ir = ins_mul;
        step();
        @(negedge clk);
        chk("fresh_start_pulse", {31'd0, ctrl_mult}, 32'd1);
        step();
        md_ready = 1'b1;
        step();
        md_ready = 1'b0;
        step();
        dx_ir = ins_nop;

        // ---------------- md_ready never arrives ----------------
        do_reset();
        step();
        dx_ir = ins_mul;
        step();                   // START
        n = 0;
`ifdef PIPE_HAZARD_MD_TIMEOUT_EN
        for (int k = 0; k < 300; k++) begin
            step();
            @(negedge clk);
            if (!md_busy) break;
            n++;
        end
        chk("wd_busy_cycles", n, 48);
        chk("wd_timeout_flag", {31'd0, md_timeout}, 32'd1);
        chk("wd_done_release", {31'd0, stall_pc_fd}, 32'd0);
        step();
        dx_ir = ins_nop;
        @(negedge clk);
        chk("wd_timeout_sticky", {31'd0, md_timeout}, 32'd1);
        do_reset();
        #1;
        chk("wd_timeout_cleared", {31'd0, md_timeout}, 32'd0);
`else
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            @(negedge clk);
            if (!(md_busy && stall_pc_fd && stall_dx)) bad++;
            n++;
        end
        chk("nowd_stall_persists", bad, 0);
        chk("nowd_stall_count", {16'd0, stall_count}, 32'd201);
        chk("nowd_timeout_zero", {31'd0, md_timeout}, 32'd0);
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- fd_ir  in  32  instruction in F/D latch
- dx_ir  in  32  instruction in D/X latch
- branch_or_jump_taken  in  1  branch/jump resolved taken in X this cycle
- md_ready  in  1  mult/div result ready pulse
- stall_pc_fd  out  1  hold PC and F/D latch
- stall_dx  out  1  hold D/X latch
- flush_fd  out  1  load nop into F/D next edge
- flush_dx  out  1  load nop into D/X next edge
- ctrl_mult  out  1  one-cycle mult start pulse
- ctrl_div  out  1  one-cycle div start pulse
- md_busy  out  1  mult/div sequence in progress
- stall_count  out  16  saturating stall-cycle counter
- md_timeout  out  1  watchdog fired (config-dependent)
REQ-002 SHALL have no parameters; opcode = ir[31:27], rd = ir[26:22], rs = ir[21:17], rt = ir[16:12], ALU op = ir[6:2].

Function
REQ-003 SHALL decode mul as opcode 00000 with ALU op 00110, and div as opcode 00000 with ALU op 00111.
REQ-004 SHALL implement the FSM IDLE, START, BUSY, DONE.
- IDLE -> START: dx_ir is mul or div.
- START -> BUSY: unconditional.
- BUSY -> DONE: md_ready.
- DONE -> IDLE: unconditional.
REQ-005 SHALL assert ctrl_mult or ctrl_div (per dx_ir) only in START, exactly one cycle per instruction.
REQ-006 SHALL assert md_busy in START and BUSY, and in IDLE when dx_ir is mul/div.
REQ-007 SHALL assert stall_pc_fd and stall_dx whenever md_busy=1, and deassert both in DONE so the instruction advances.
REQ-008 SHALL flag load-use when dx_ir opcode is 01000 (lw), dx rd != 0, and dx rd equals a source of fd_ir.
- rs is a source for opcodes 00000, 00101, 00111, 01000, 00010, 00110.
- rt is a source for opcode 00000.
- rd is a source for opcodes 00111, 00010, 00110, 00100.
REQ-009 SHALL, on load-use with md_busy=0, assert stall_pc_fd and flush_dx for that cycle only, with stall_dx=0.
REQ-010 SHALL, on branch_or_jump_taken=1, assert flush_fd and flush_dx, and force stall_pc_fd=0 and stall_dx=0.
REQ-011 SHALL give md_busy priority over load-use; branch_or_jump_taken while md_busy=1 SHALL be ignored, since dx_ir is mul/div.
REQ-012 SHALL make all outputs except ctrl_mult, ctrl_div, stall_count and md_timeout combinational from state and inputs, with zero-cycle latency.
REQ-013 SHALL increment stall_count on each edge where stall_pc_fd=1, saturating at 16'hFFFF.
REQ-014 SHALL ignore md_ready outside BUSY.
REQ-015 SHALL treat back-to-back mul/div (new one in dx_ir the cycle after DONE) as a fresh IDLE -> START sequence.

Reset
REQ-016 SHALL, on reset=0, immediately force state IDLE, stall_count=0, md_timeout=0, and ctrl_mult=ctrl_div=0, independent of clock.
REQ-017 SHALL abandon a mid-sequence mult/div on reset with no further start pulse; a fresh start SHALL be issued only when IDLE sees mul/div in dx_ir after release.

Configuration
REQ-018 SHALL implement a watchdog only when PIPE_HAZARD_MD_TIMEOUT_EN is defined.
- Defined: a 6-bit counter clears in START and increments in BUSY; at count 47 with md_ready=0, go to DONE and set md_timeout=1 (sticky until reset).
- Undefined: BUSY waits indefinitely, no counter exists, and md_timeout is tied 0.

Verification
REQ-019 Reset held low mid-BUSY -> state IDLE, all outputs 0, stall_count=0 asynchronously.
REQ-020 dx_ir=mul, md_ready 5 cycles after START -> ctrl_mult one pulse, stall 7 cycles (IDLE, START, BUSY x5), stall_count=7, release in DONE.
REQ-021 dx_ir=lw r3, fd_ir=add r4,r3,r5 -> stall_pc_fd=1 and flush_dx=1 for one cycle; same with lw r0 -> no stall.
REQ-022 branch_or_jump_taken=1 with dx_ir=bne -> flush_fd=flush_dx=1, stalls 0.
REQ-023 div followed directly by mul -> two distinct start pulses, with DONE between them.
REQ-024 With PIPE_HAZARD_MD_TIMEOUT_EN, md_ready never asserted -> DONE after 48 BUSY cycles, md_timeout=1; without it -> stall persists for 200 cycles.
